// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
package seg_pkg;

    typedef enum logic [0:0] {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } slot_state_t;

    // All segments dark in the internal active-low representation.
    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Active-low g..a patterns; element i is the glyph for hex digit i.
    localparam logic [15:0][7:0] SEG_LUT = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble + decimal point to active-low segment pattern.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] seg_n
);

    assign seg_n = {~dp, SEG_LUT[nibble][6:0]};

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scanner: dead-time blanking, PWM brightness, double-buffered load.
// Optional leading-zero blanking when SEG_SCAN_LZB_EN is defined.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIGITS         = 8,
    parameter int DWELL_CYC      = 50000,
    parameter int BLANK_CYC      = 50,
    parameter int SEL_ACTIVE_LOW = 0,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [4*DIGITS-1:0]   Disp_Data,
    input  logic [DIGITS-1:0]     Dp_In,
    input  logic [DIGITS-1:0]     Blank_In,
    input  logic [3:0]            Brightness,
    input  logic                  Load,
    output logic                  Load_Ack,
    output logic                  Frame_Start,
    output logic [DIGITS-1:0]     SEL,
    output logic [7:0]            SEG
);

    localparam int IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_W    = $clog2(DWELL_CYC + 1);
    localparam int SHOW_CYC = DWELL_CYC - BLANK_CYC;

    localparam logic [DIGITS-1:0] SEL_IDLE = (SEL_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
    localparam logic [7:0]        SEG_IDLE = (SEG_ACTIVE_LOW != 0) ? SEG_OFF : ~SEG_OFF;

    slot_state_t          state_reg, state_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [IDX_W-1:0]     digit_reg, digit_next;
    logic [3:0]           pwm_reg, pwm_next;

    logic [4*DIGITS-1:0]  pend_data_reg, act_data_reg;
    logic [DIGITS-1:0]    pend_dp_reg, act_dp_reg;
    logic [DIGITS-1:0]    pend_blank_reg, act_blank_reg;
    logic                 pend_valid_reg, pend_valid_next;

    logic [DIGITS-1:0]    sel_reg, sel_next;
    logic [7:0]           seg_reg, seg_next;
    logic                 frame_start_reg, load_ack_reg;

    logic                 blank_end, slot_end, frame_wrap;
    logic [DIGITS-1:0]    dark_vec;
    logic [DIGITS-1:0]    sel_on;
    logic [3:0]           cur_nibble;
    logic                 cur_dp, cur_dark, lit;
    logic [7:0]           glyph_n, seg_low;

    assign blank_end  = (state_reg == BLANK) && (cnt_reg == CNT_W'(BLANK_CYC - 1));
    assign slot_end   = (state_reg == SHOW)  && (cnt_reg == CNT_W'(SHOW_CYC - 1));
    assign frame_wrap = slot_end && (digit_reg == IDX_W'(DIGITS - 1));

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + 1'b1;
        digit_next = digit_reg;
        pwm_next   = 4'h0;
        if (state_reg == BLANK) begin
            if (blank_end) begin
                state_next = SHOW;
                cnt_next   = '0;
            end
        end else begin
            pwm_next = pwm_reg + 4'h1;
            if (slot_end) begin
                state_next = BLANK;
                cnt_next   = '0;
                digit_next = frame_wrap ? '0 : digit_reg + 1'b1;
            end
        end
    end

    // A Load coinciding with the frame wrap re-arms pending after the old contents move out.
    assign pend_valid_next = Load ? 1'b1 : (frame_wrap ? 1'b0 : pend_valid_reg);

`ifdef SEG_SCAN_LZB_EN
    logic [DIGITS-1:0] dig_zero;
    logic              lead_run;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_zero
        assign dig_zero[gi] = (act_data_reg[4*gi +: 4] == 4'h0) && !act_dp_reg[gi];
    end

    // Walk from the most significant digit down; digit 0 always shows.
    always_comb begin
        lead_run = 1'b1;
        dark_vec = act_blank_reg;
        for (int k = DIGITS - 1; k > 0; k--) begin
            lead_run    = lead_run & dig_zero[k];
            dark_vec[k] = act_blank_reg[k] | lead_run;
        end
    end
`else
    assign dark_vec = act_blank_reg;
`endif

    always_comb begin
        cur_nibble = 4'h0;
        cur_dp     = 1'b0;
        cur_dark   = 1'b1;
        sel_on     = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (digit_reg == IDX_W'(k)) begin
                cur_nibble = act_data_reg[4*k +: 4];
                cur_dp     = act_dp_reg[k];
                cur_dark   = dark_vec[k];
                sel_on[k]  = (state_reg == SHOW);
            end
        end
    end

    seg_hex_decode u_decode (
        .nibble (cur_nibble),
        .dp     (cur_dp),
        .seg_n  (glyph_n)
    );

    assign lit      = (state_reg == SHOW) && !cur_dark && (pwm_reg <= Brightness);
    assign seg_low  = lit ? glyph_n : SEG_OFF;
    assign seg_next = (SEG_ACTIVE_LOW != 0) ? seg_low : ~seg_low;
    assign sel_next = (SEL_ACTIVE_LOW != 0) ? ~sel_on : sel_on;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg       <= BLANK;
            cnt_reg         <= '0;
            digit_reg       <= '0;
            pwm_reg         <= 4'h0;
            pend_data_reg   <= '0;
            pend_dp_reg     <= '0;
            pend_blank_reg  <= '1;
            pend_valid_reg  <= 1'b0;
            act_data_reg    <= '0;
            act_dp_reg      <= '0;
            act_blank_reg   <= '1;
            sel_reg         <= SEL_IDLE;
            seg_reg         <= SEG_IDLE;
            frame_start_reg <= 1'b0;
            load_ack_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            digit_reg       <= digit_next;
            pwm_reg         <= pwm_next;
            pend_valid_reg  <= pend_valid_next;
            if (Load) begin
                pend_data_reg  <= Disp_Data;
                pend_dp_reg    <= Dp_In;
                pend_blank_reg <= Blank_In;
            end
            if (frame_wrap && pend_valid_reg) begin
                act_data_reg  <= pend_data_reg;
                act_dp_reg    <= pend_dp_reg;
                act_blank_reg <= pend_blank_reg;
            end
            sel_reg         <= sel_next;
            seg_reg         <= seg_next;
            frame_start_reg <= (state_reg == BLANK) && (cnt_reg == '0) && (digit_reg == '0);
            load_ack_reg    <= Load;
        end
    end

    assign SEL         = sel_reg;
    assign SEG         = seg_reg;
    assign Frame_Start = frame_start_reg;
    assign Load_Ack    = load_ack_reg;

endmodule
